// File: rtl/host_pkg.sv
// Shared types for the host launcher: sequencer states and counter width.
package host_pkg;

  localparam int CNT_W = 12;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    BOOT,
    RUN,
    DUMP
  } state_e;

endpackage

// File: rtl/host_launcher_sat_counter.sv
// Saturating up-counter timing the RUN phase of the host launcher.
module sat_counter
  import host_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] q,
  output logic [CNT_W-1:0] nxt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    nxt   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/host_launcher.sv
// Host-side sequencer: preloads data memory, boots and times the processor,
// then streams a result window back out.
module host_launcher
  import host_pkg::*;
#(
  parameter logic [7:0]       LOAD_BASE = 8'd0,
  parameter int               LOAD_LEN  = 16,
  parameter logic [7:0]       DUMP_BASE = 8'd64,
  parameter int               DUMP_LEN  = 16,
  parameter logic [CNT_W-1:0] TIMEOUT   = 12'd4095
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             mem_wr_en,
  output logic [7:0]       mem_addr,
  output logic [7:0]       mem_wr_data,
  input  logic [7:0]       mem_rd_data,
  output logic             dut_reset,
  output logic             dut_req,
  input  logic             dut_done,
  output logic             out_valid,
  output logic [7:0]       out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             timeout,
  output logic [CNT_W-1:0] cycles
);

  state_e           state_q, state_d;
  logic [7:0]       ptr_q, ptr_d;
  logic             timeout_q, timeout_d;
  logic             cnt_clr, cnt_en;
  logic [CNT_W-1:0] cnt_nxt;

  localparam logic [7:0] LOAD_LAST = 8'(LOAD_LEN - 1);
  localparam logic [7:0] DUMP_LAST = 8'(DUMP_LEN - 1);

  sat_counter u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .q     (cycles),
    .nxt   (cnt_nxt)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    timeout_d   = timeout_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    in_ready    = 1'b0;
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    dut_req     = 1'b0;
    out_valid   = 1'b0;
    out_data    = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LOAD;
          ptr_d     = '0;
          timeout_d = 1'b0;
          cnt_clr   = 1'b1;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        mem_addr = LOAD_BASE + ptr_q;
        if (in_valid) begin
          mem_wr_en   = 1'b1;
          mem_wr_data = in_data;
          if (ptr_q == LOAD_LAST) begin
            ptr_d   = '0;
            state_d = BOOT;
          end else begin
            ptr_d = ptr_q + 8'd1;
          end
        end
      end
      BOOT: state_d = RUN;
      RUN: begin
        dut_req = 1'b1;
        cnt_en  = 1'b1;
        // Completion takes priority over a timeout landing on the same cycle.
        if (dut_done) begin
          state_d = DUMP;
        end else if (cnt_nxt == TIMEOUT) begin
          timeout_d = 1'b1;
          state_d   = DUMP;
        end
      end
      DUMP: begin
        mem_addr  = DUMP_BASE + ptr_q;
        out_valid = 1'b1;
        out_data  = mem_rd_data;
        if (out_ready) begin
          if (ptr_q == DUMP_LAST) begin
            ptr_d   = '0;
            state_d = IDLE;
          end else begin
            ptr_d = ptr_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      timeout_q <= timeout_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign timeout   = timeout_q;
  assign dut_reset = reset | (state_q == BOOT);

endmodule

// File: tb/tb_host_launcher.sv
// Directed bench for host_launcher: default instance plus a wrapped-base,
// short-timeout instance.
module tb_host_launcher;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        b_start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        dut_done = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, mem_wr_en, dut_reset, dut_req;
  logic        out_valid, busy, timeout;
  logic [7:0]  mem_addr, mem_wr_data, mem_rd_data, out_data;
  logic [11:0] cycles;

  logic        b_in_ready, b_mem_wr_en, b_dut_reset, b_dut_req;
  logic        b_out_valid, b_busy, b_timeout;
  logic [7:0]  b_mem_addr, b_mem_wr_data, b_mem_rd_data, b_out_data;
  logic [11:0] b_cycles;

  int vec = 0;
  int err = 0;

  always #5 clk = ~clk;

  // Memory read model: contents are a fixed function of the address.
  assign mem_rd_data   = mem_addr ^ 8'h5A;
  assign b_mem_rd_data = b_mem_addr ^ 8'h5A;

  host_launcher dut_a (
    .clk(clk), .reset(rst), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .dut_reset(dut_reset), .dut_req(dut_req), .dut_done(dut_done),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .timeout(timeout), .cycles(cycles)
  );

  host_launcher #(
    .LOAD_BASE(8'd250), .LOAD_LEN(10), .DUMP_LEN(2), .TIMEOUT(12'd20)
  ) dut_b (
    .clk(clk), .reset(rst), .start(b_start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(b_in_ready),
    .mem_wr_en(b_mem_wr_en), .mem_addr(b_mem_addr),
    .mem_wr_data(b_mem_wr_data), .mem_rd_data(b_mem_rd_data),
    .dut_reset(b_dut_reset), .dut_req(b_dut_req), .dut_done(dut_done),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(out_ready),
    .busy(b_busy), .timeout(b_timeout), .cycles(b_cycles)
  );

  task automatic start_a();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Streams 16 words; ends at the first RUN negedge.
  task automatic load_a();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h10 + 8'(i);
      #1;
      vec++;
      if (mem_wr_en !== 1'b1 || in_ready !== 1'b1) begin
        err++;
        $display("FAIL load_we[%0d] got we=%0b rdy=%0b exp 1", i, mem_wr_en, in_ready);
      end
      vec++;
      if (mem_addr !== 8'(i) || mem_wr_data !== 8'h10 + 8'(i)) begin
        err++;
        $display("FAIL load_addr[%0d] got %0d/%0h exp %0d/%0h", i, mem_addr, mem_wr_data, i, 8'h10 + 8'(i));
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    vec++;
    if (dut_reset !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0 || mem_wr_en !== 1'b0) begin
      err++;
      $display("FAIL boot got rst=%0b busy=%0b rdy=%0b we=%0b exp 1 1 0 0", dut_reset, busy, in_ready, mem_wr_en);
    end
    @(negedge clk);
    #1;
    vec++;
    if (dut_reset !== 1'b0 || dut_req !== 1'b1) begin
      err++;
      $display("FAIL run_entry got rst=%0b req=%0b exp 0 1", dut_reset, dut_req);
    end
  endtask

  task automatic dump_a(input bit toggle);
    int idx = 0;
    int cyc = 0;
    while (idx < 16 && cyc < 100) begin
      out_ready = toggle ? cyc[0] : 1'b1;
      #1;
      vec++;
      if (out_valid !== 1'b1 || mem_addr !== 8'(64 + idx)) begin
        err++;
        $display("FAIL dump_addr[%0d] got v=%0b a=%0d exp 1 %0d", idx, out_valid, mem_addr, 64 + idx);
      end
      vec++;
      if (out_data !== (8'(64 + idx) ^ 8'h5A)) begin
        err++;
        $display("FAIL dump_data[%0d] got %0h exp %0h", idx, out_data, 8'(64 + idx) ^ 8'h5A);
      end
      if (out_ready) idx++;
      cyc++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    #1;
    vec++;
    if (idx != 16 || busy !== 1'b0 || out_valid !== 1'b0) begin
      err++;
      $display("FAIL dump_end got n=%0d busy=%0b v=%0b exp 16 0 0", idx, busy, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vec++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || mem_wr_en !== 1'b0 || dut_req !== 1'b0 || out_valid !== 1'b0) begin
      err++;
      $display("FAIL rst_ctl got busy=%0b rdy=%0b we=%0b req=%0b v=%0b exp 0", busy, in_ready, mem_wr_en, dut_req, out_valid);
    end
    vec++;
    if (dut_reset !== 1'b1 || cycles !== 12'd0 || timeout !== 1'b0 || mem_addr !== 8'd0) begin
      err++;
      $display("FAIL rst_val got drst=%0b cyc=%0d to=%0b a=%0d exp 1 0 0 0", dut_reset, cycles, timeout, mem_addr);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_run_done();
    start_a();
    load_a();
    for (int k = 1; k <= 37; k++) begin
      dut_done = (k == 37);
      start    = (k == 5);
      @(negedge clk);
    end
    dut_done = 1'b0;
    start    = 1'b0;
    #1;
    vec++;
    if (cycles !== 12'd37 || timeout !== 1'b0 || dut_req !== 1'b0) begin
      err++;
      $display("FAIL run_done got cyc=%0d to=%0b req=%0b exp 37 0 0", cycles, timeout, dut_req);
    end
    dump_a(1'b1);
    vec++;
    if (cycles !== 12'd37) begin
      err++;
      $display("FAIL idle_hold got cyc=%0d exp 37", cycles);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    start_a();
    load_a();
    while (dut_req === 1'b1 && n < 5000) begin
      n++;
      @(negedge clk);
    end
    #1;
    vec++;
    if (n != 4095 || timeout !== 1'b1 || cycles !== 12'd4095) begin
      err++;
      $display("FAIL timeout got n=%0d to=%0b cyc=%0d exp 4095 1 4095", n, timeout, cycles);
    end
    dump_a(1'b0);
    vec++;
    if (timeout !== 1'b1) begin
      err++;
      $display("FAIL to_sticky got %0b exp 1", timeout);
    end
  endtask

  task automatic run_b(input bit done_at_limit);
    int n = 0;
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hC0 + 8'(i);
      #1;
      vec++;
      if (b_mem_wr_en !== 1'b1 || b_mem_addr !== 8'(250 + i)) begin
        err++;
        $display("FAIL wrap_addr[%0d] got we=%0b a=%0d exp 1 %0d", i, b_mem_wr_en, b_mem_addr, 8'(250 + i));
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    while (b_dut_req === 1'b1 && n < 100) begin
      n++;
      dut_done = done_at_limit && (n == 20);
      @(negedge clk);
    end
    dut_done = 1'b0;
    #1;
    vec++;
    if (n != 20 || b_cycles !== 12'd20 || b_timeout !== !done_at_limit) begin
      err++;
      $display("FAIL b_run%0b got n=%0d cyc=%0d to=%0b exp 20 20 %0b", done_at_limit, n, b_cycles, b_timeout, !done_at_limit);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      vec++;
      if (b_out_valid !== 1'b1 || b_out_data !== (8'(64 + i) ^ 8'h5A)) begin
        err++;
        $display("FAIL b_dump[%0d] got v=%0b d=%0h exp 1 %0h", i, b_out_valid, b_out_data, 8'(64 + i) ^ 8'h5A);
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    #1;
    vec++;
    if (b_busy !== 1'b0) begin
      err++;
      $display("FAIL b_idle got %0b exp 0", b_busy);
    end
  endtask

  task automatic test_reset_mid_load();
    start_a();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h30 + 8'(i);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    vec++;
    if (busy !== 1'b0 || mem_wr_en !== 1'b0 || in_ready !== 1'b0 || dut_reset !== 1'b1) begin
      err++;
      $display("FAIL mid_rst got busy=%0b we=%0b rdy=%0b drst=%0b exp 0 0 0 1", busy, mem_wr_en, in_ready, dut_reset);
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    start_a();
    load_a();
    dut_done = 1'b1;
    @(negedge clk);
    dut_done = 1'b0;
    #1;
    vec++;
    if (cycles !== 12'd1 || out_valid !== 1'b1) begin
      err++;
      $display("FAIL restart_run got cyc=%0d v=%0b exp 1 1", cycles, out_valid);
    end
    dump_a(1'b0);
  endtask

  initial begin
    test_reset();
    test_run_done();
    run_b(1'b1);
    run_b(1'b0);
    test_timeout();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
